// File: rtl/mem_req_arb_if.sv
// Bus bundle for mem_req_arb: the two requester ports and the memory request/response channel.
// slave is the arbiter's view; master is the view of whatever drives the requesters and memory.
interface mem_req_arb_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
);
    logic [1:0]                 req_val_i;
    logic [1:0]                 req_typ_i;
    logic [1:0][ADDR_WIDTH-1:0] req_addr_i;
    logic [1:0][DATA_WIDTH-1:0] req_data_i;
    logic [1:0]                 req_rdy_o;
    logic [1:0]                 rsp_val_o;
    logic [DATA_WIDTH-1:0]      rsp_data_o;
    logic [1:0]                 rsp_rdy_i;
    logic                       mem_req_val_o;
    logic                       mem_req_typ_o;
    logic [ADDR_WIDTH-1:0]      mem_req_addr_o;
    logic [DATA_WIDTH-1:0]      mem_req_data_o;
    logic                       mem_req_rdy_i;
    logic                       mem_rsp_val_i;
    logic [DATA_WIDTH-1:0]      mem_rsp_data_i;
    logic                       mem_rsp_rdy_o;

    modport slave (
        input  req_val_i, req_typ_i, req_addr_i, req_data_i, rsp_rdy_i,
               mem_req_rdy_i, mem_rsp_val_i, mem_rsp_data_i,
        output req_rdy_o, rsp_val_o, rsp_data_o,
               mem_req_val_o, mem_req_typ_o, mem_req_addr_o, mem_req_data_o, mem_rsp_rdy_o
    );

    modport master (
        output req_val_i, req_typ_i, req_addr_i, req_data_i, rsp_rdy_i,
               mem_req_rdy_i, mem_rsp_val_i, mem_rsp_data_i,
        input  req_rdy_o, rsp_val_o, rsp_data_o,
               mem_req_val_o, mem_req_typ_o, mem_req_addr_o, mem_req_data_o, mem_rsp_rdy_o
    );
endinterface

// File: rtl/mem_req_arb.sv
// Two-requester round-robin arbiter in front of a single memory req/rsp channel.
// An in-order tag FIFO remembers which requester owns each outstanding request.
module mem_req_arb #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32,
    parameter int ID_DEPTH   = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    mem_req_arb_if.slave                 bus,
    output logic [$clog2(ID_DEPTH+1)-1:0] outstanding_o,
    output logic                         err_o
);
    localparam int PW = $clog2(ID_DEPTH);
    localparam int CW = $clog2(ID_DEPTH + 1);

    logic                  prio_q;
    logic [ID_DEPTH-1:0]   fifo_q;
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  err_q;

    logic                  grant;
    logic                  any_req;
    logic                  full;
    logic                  empty;
    logic                  accept;
    logic                  pop;
    logic                  head;
    logic                  gnt_typ;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_data;

    // A lone requester always wins; a tie goes to prio_q.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it
        // holding its old value and a latch is never inferred.
        grant = prio_q;
        case (bus.req_val_i)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            default: grant = prio_q;
        endcase
    end

    assign any_req = |bus.req_val_i;
    assign full    = (count_q == CW'(ID_DEPTH));
    assign empty   = (count_q == '0);

    always_comb begin
        gnt_typ  = 1'b0;
        gnt_addr = '0;
        gnt_data = '0;
        if (any_req) begin
            gnt_typ  = bus.req_typ_i[grant];
            gnt_addr = bus.req_addr_i[grant];
            gnt_data = bus.req_data_i[grant];
        end
    end

    // Full blocks new requests even when a pop frees a slot in the same cycle.
    assign bus.mem_req_val_o  = any_req && !full;
    assign bus.mem_req_typ_o  = gnt_typ;
    assign bus.mem_req_addr_o = gnt_addr;
    assign bus.mem_req_data_o = gnt_data;

    assign accept        = bus.mem_req_val_o && bus.mem_req_rdy_i;
    assign bus.req_rdy_o = {accept && grant, accept && !grant};

    assign head              = fifo_q[rd_ptr_q];
    assign bus.rsp_data_o    = bus.mem_rsp_data_i;
    assign bus.mem_rsp_rdy_o = !empty && bus.rsp_rdy_i[head];
    assign bus.rsp_val_o     = empty ? 2'b00
                             : (head ? {bus.mem_rsp_val_i, 1'b0} : {1'b0, bus.mem_rsp_val_i});
    assign pop               = bus.mem_rsp_val_i && bus.mem_rsp_rdy_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the tag FIFO is only ID_DEPTH flops, so it is reset with the rest of the state;
            // a real RAM array would be left unreset and guarded by the pointers instead.
            prio_q   <= 1'b0;
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples
            // pre-edge values, independent of statement order.
            if (accept) begin
                fifo_q[wr_ptr_q] <= grant;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
                prio_q           <= ~grant;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (bus.mem_rsp_val_i && empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign outstanding_o = count_q;
    assign err_o         = err_q;
endmodule

// File: tb/tb_mem_req_arb.sv
// Directed bench for mem_req_arb: reset, single grants, round-robin ties, full stall,
// head-of-line response steering and reset with requests in flight.
module tb_mem_req_arb;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [2:0] outstanding;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_req_arb_if #(.ADDR_WIDTH(7), .DATA_WIDTH(32)) bus ();

    mem_req_arb #(.ADDR_WIDTH(7), .DATA_WIDTH(32), .ID_DEPTH(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .bus           (bus),
        .outstanding_o (outstanding),
        .err_o         (err)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_i              = 1'b1;
        bus.req_val_i      = 2'b00;
        bus.req_typ_i      = 2'b00;
        bus.req_addr_i     = '0;
        bus.req_data_i     = '0;
        bus.rsp_rdy_i      = 2'b00;
        bus.mem_req_rdy_i  = 1'b0;
        bus.mem_rsp_val_i  = 1'b0;
        bus.mem_rsp_data_i = '0;

        // Outputs while reset is held
        tick(); settle();
        chk("rst_req_rdy", bus.req_rdy_o, 2'b00);
        chk("rst_rsp_val", bus.rsp_val_o, 2'b00);
        chk("rst_mem_req_val", bus.mem_req_val_o, 1'b0);
        chk("rst_mem_rsp_rdy", bus.mem_rsp_rdy_o, 1'b0);
        chk("rst_outstanding", outstanding, 3'd0);
        chk("rst_err", err, 1'b0);
        rst_i = 1'b0;

        // Idle after reset
        tick(); settle();
        chk("idle_mem_req_val", bus.mem_req_val_o, 1'b0);
        chk("idle_mem_req_addr", bus.mem_req_addr_o, 7'h00);
        chk("idle_outstanding", outstanding, 3'd0);

        // Requester 0 alone: read 0x05, then its response
        tick();
        bus.req_val_i     = 2'b01;
        bus.req_typ_i     = 2'b00;
        bus.req_addr_i[0] = 7'h05;
        bus.mem_req_rdy_i = 1'b1;
        settle();
        chk("r0_req_rdy", bus.req_rdy_o, 2'b01);
        chk("r0_mem_req_val", bus.mem_req_val_o, 1'b1);
        chk("r0_mem_req_addr", bus.mem_req_addr_o, 7'h05);
        chk("r0_mem_req_typ", bus.mem_req_typ_o, 1'b0);
        tick();
        bus.req_val_i      = 2'b00;
        bus.mem_rsp_val_i  = 1'b1;
        bus.mem_rsp_data_i = 32'hDEADBEEF;
        bus.rsp_rdy_i      = 2'b01;
        settle();
        chk("r0_outstanding", outstanding, 3'd1);
        chk("r0_rsp_val", bus.rsp_val_o, 2'b01);
        chk("r0_rsp_data", bus.rsp_data_o, 32'hDEADBEEF);
        chk("r0_mem_rsp_rdy", bus.mem_rsp_rdy_o, 1'b1);

        // Requester 1 alone: write 0x12345678 to 0x7F (prio becomes 0 afterwards)
        tick();
        bus.mem_rsp_val_i = 1'b0;
        bus.req_val_i     = 2'b10;
        bus.req_typ_i     = 2'b10;
        bus.req_addr_i[1] = 7'h7F;
        bus.req_data_i[1] = 32'h12345678;
        settle();
        chk("r1_outstanding_before", outstanding, 3'd0);
        chk("r1_req_rdy", bus.req_rdy_o, 2'b10);
        chk("r1_mem_req_typ", bus.mem_req_typ_o, 1'b1);
        chk("r1_mem_req_addr", bus.mem_req_addr_o, 7'h7F);
        chk("r1_mem_req_data", bus.mem_req_data_o, 32'h12345678);
        tick();
        bus.req_val_i      = 2'b00;
        bus.mem_rsp_val_i  = 1'b1;
        bus.mem_rsp_data_i = 32'h0000_0001;
        bus.rsp_rdy_i      = 2'b11;
        settle();
        chk("r1_rsp_val", bus.rsp_val_o, 2'b10);

        // Both requesters valid for 4 cycles: grants alternate 0,1,0,1
        tick();
        bus.mem_rsp_val_i = 1'b0;
        bus.req_val_i     = 2'b11;
        bus.req_typ_i     = 2'b00;
        bus.req_addr_i[0] = 7'h10;
        bus.req_addr_i[1] = 7'h20;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("rr_req_rdy_%0d", i), bus.req_rdy_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("rr_addr_%0d", i), bus.mem_req_addr_o, (i % 2 == 0) ? 7'h10 : 7'h20);
            tick();
        end
        bus.req_val_i = 2'b00;
        settle();
        chk("rr_outstanding", outstanding, 3'd4);
        // Responses come back in grant order
        tick();
        bus.mem_rsp_val_i = 1'b1;
        bus.rsp_rdy_i     = 2'b11;
        for (int i = 0; i < 4; i++) begin
            bus.mem_rsp_data_i = 32'hA000_0000 + 32'(i);
            settle();
            chk($sformatf("rr_rsp_val_%0d", i), bus.rsp_val_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("rr_rsp_data_%0d", i), bus.rsp_data_o, 32'hA000_0000 + 32'(i));
            tick();
        end
        bus.mem_rsp_val_i = 1'b0;
        settle();
        chk("rr_drained", outstanding, 3'd0);

        // Fill the tag FIFO with no responses, then stall
        tick();
        bus.req_val_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        settle();
        chk("full_outstanding", outstanding, 3'd4);
        chk("full_mem_req_val", bus.mem_req_val_o, 1'b0);
        chk("full_req_rdy", bus.req_rdy_o, 2'b00);
        // A pop in the same cycle does not reopen the request channel
        tick();
        bus.mem_rsp_val_i = 1'b1;
        settle();
        chk("full_pop_rsp_val", bus.rsp_val_o, 2'b01);
        chk("full_pop_mem_req_val", bus.mem_req_val_o, 1'b0);
        tick();
        bus.mem_rsp_val_i = 1'b0;
        settle();
        chk("after_pop_outstanding", outstanding, 3'd3);
        chk("after_pop_req_rdy", bus.req_rdy_o, 2'b01);
        tick();
        bus.req_val_i = 2'b00;
        settle();
        chk("refill_outstanding", outstanding, 3'd4);

        // Head tag is 1: requester 0 ready only holds the response
        bus.mem_rsp_val_i = 1'b1;
        bus.rsp_rdy_i     = 2'b01;
        settle();
        chk("hol_mem_rsp_rdy", bus.mem_rsp_rdy_o, 1'b0);
        chk("hol_rsp_val", bus.rsp_val_o, 2'b10);
        tick();
        settle();
        chk("hol_held_outstanding", outstanding, 3'd4);
        bus.rsp_rdy_i = 2'b10;
        settle();
        chk("hol_release_rdy", bus.mem_rsp_rdy_o, 1'b1);
        tick();
        bus.mem_rsp_val_i = 1'b0;
        settle();
        chk("hol_pop_outstanding", outstanding, 3'd3);

        // Drain one more to leave 2 outstanding, then reset
        bus.mem_rsp_val_i = 1'b1;
        bus.rsp_rdy_i     = 2'b11;
        tick();
        bus.mem_rsp_val_i = 1'b0;
        settle();
        chk("pre_rst_outstanding", outstanding, 3'd2);
        rst_i = 1'b1;
        settle();
        chk("mid_rst_outstanding", outstanding, 3'd0);
        tick();
        rst_i              = 1'b0;
        bus.mem_rsp_val_i  = 1'b1;
        bus.mem_rsp_data_i = 32'h5555_AAAA;
        settle();
        chk("post_rst_mem_rsp_rdy", bus.mem_rsp_rdy_o, 1'b0);
        chk("post_rst_rsp_val", bus.rsp_val_o, 2'b00);
        chk("post_rst_err_pre", err, 1'b0);
        tick();
        bus.mem_rsp_val_i = 1'b0;
        settle();
        chk("post_rst_err", err, 1'b1);
        tick();
        settle();
        chk("err_sticky", err, 1'b1);
        chk("post_rst_outstanding", outstanding, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
